// File: rtl/mips_mem_responder_pkg.sv
// rtl/mips_mem_responder_pkg.sv - shared types and constants for the MIPS memory responder
package mips_mem_responder_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int LANE_W = 2;
    localparam int BYTE_W = 8;

    // Big-endian packing: lane 0 lands in bits 31:24, lane 3 in bits 7:0.
    function automatic logic [4:0] lane_shift(input logic [LANE_W-1:0] lane);
        return 5'd24 - {lane, 3'b000};
    endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// rtl/mips_mem_responder_if.sv - core instruction/data ports and program loader stream
interface mips_mem_responder_if;

    logic [31:0] inst_adr;
    logic [31:0] inst;
    logic [31:0] data_adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_rst;
    logic        ld_overflow;

    modport master (
        output inst_adr, data_adr, wdata, mem_read, mem_write,
        output ld_valid, ld_data, ld_last,
        input  inst, rdata, ld_ready, cpu_rst, ld_overflow
    );

    modport slave (
        input  inst_adr, data_adr, wdata, mem_read, mem_write,
        input  ld_valid, ld_data, ld_last,
        output inst, rdata, ld_ready, cpu_rst, ld_overflow
    );

endinterface

// File: rtl/mips_mem_responder_mem_ram.sv
// rtl/mips_mem_responder_mem_ram.sv - word RAM with clocked write and asynchronous read
module mips_mem_responder_mem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - IMEM/DMEM responder for a single-cycle MIPS core with program loader
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_mem_responder_if.slave  bus
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    state_t            r_state, w_state_nxt;
    logic [LANE_W-1:0] r_lane, w_lane_nxt;
    logic [IAW:0]      r_word_ptr, w_word_ptr_nxt;
    logic [31:0]       r_pack, w_pack_nxt;
    logic              r_overflow, w_overflow_nxt;

    logic        w_run;
    logic [31:0] w_word;
    logic        w_imem_we;
    logic        w_dmem_we;
    logic [31:0] w_imem_rdata;
    logic [31:0] w_dmem_rdata;
    logic        w_unused;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LOAD;
            r_lane     <= '0;
            r_word_ptr <= '0;
            r_pack     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane     <= w_lane_nxt;
            r_word_ptr <= w_word_ptr_nxt;
            r_pack     <= w_pack_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lane_nxt     = r_lane;
        w_word_ptr_nxt = r_word_ptr;
        w_pack_nxt     = r_pack;
        w_overflow_nxt = r_overflow;
        w_imem_we      = 1'b0;
        w_word         = r_pack | ({24'd0, bus.ld_data} << lane_shift(r_lane));
        case (r_state)
            LOAD: begin
                if (bus.ld_valid) begin
                    // Lower lanes of r_pack are still zero, so a short final word is zero-filled.
                    if (r_lane == 2'd3 || bus.ld_last) begin
                        w_lane_nxt = '0;
                        w_pack_nxt = '0;
                        if (r_word_ptr == (IAW+1)'(IMEM_WORDS)) begin
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_imem_we      = 1'b1;
                            w_word_ptr_nxt = r_word_ptr + (IAW+1)'(1);
                        end
                    end else begin
                        w_lane_nxt = r_lane + LANE_W'(1);
                        w_pack_nxt = w_word;
                    end
                    if (bus.ld_last) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = LOAD;
        endcase
    end

    assign w_run     = (r_state == RUN);
    assign w_dmem_we = w_run & bus.mem_write;

    mips_mem_responder_mem_ram #(.DEPTH(IMEM_WORDS)) u_imem (
        .i_clk   (clk),
        .i_we    (w_imem_we),
        .i_waddr (r_word_ptr[IAW-1:0]),
        .i_wdata (w_word),
        .i_raddr (bus.inst_adr[IAW+1:2]),
        .o_rdata (w_imem_rdata)
    );

    mips_mem_responder_mem_ram #(.DEPTH(DMEM_WORDS)) u_dmem (
        .i_clk   (clk),
        .i_we    (w_dmem_we),
        .i_waddr (bus.data_adr[DAW+1:2]),
        .i_wdata (bus.wdata),
        .i_raddr (bus.data_adr[DAW+1:2]),
        .o_rdata (w_dmem_rdata)
    );

    assign bus.ld_ready    = ~w_run;
    assign bus.cpu_rst     = ~w_run;
    assign bus.ld_overflow = r_overflow;
    assign bus.inst        = w_run ? w_imem_rdata : 32'd0;
    assign bus.rdata       = (w_run && bus.mem_read) ? w_dmem_rdata : 32'd0;

    // Address bits outside the word index are ignored so the arrays wrap modulo depth.
    assign w_unused = ^{bus.inst_adr[31:IAW+2], bus.inst_adr[1:0],
                        bus.data_adr[31:DAW+2], bus.data_adr[1:0]};

endmodule
